gcd_datapath: RTL and testbench

GCD_DATAPATH -- requirements
Module: gcd_datapath

---
 rtl/gcd_datapath.sv | 136 +++++++++++++
 tb/tb_gcd_datapath.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gcd_datapath.sv
// -----------------------------------------------------------------------------
// gcd_datapath
//
// Datapath half of a subtract-and-swap GCD engine. An external control unit
// drives one command per cycle on controlarr. In return it reads endflag
// (Y == 0) and swapflag (X < Y) to decide the next step.
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   reset       synchronous, active-high; clears X, Y, done, err (and counter)
//   controlarr  [0] subtract, [1] swap, [2] load-select,
//               [3] X write enable, [4] Y write enable
//   xin, yin    operands captured by a load command
//   endflag     Y == 0 (combinational from the registers)
//   swapflag    X <  Y, unsigned (combinational from the registers)
//   result      current X value; holds the GCD once done is set
//   done        set on the first non-load edge that sees endflag,
//               cleared by load or reset
//   err         sticky illegal-command flag, cleared only by reset
//   iter_count  saturating count of executed subtracts
//               (only when GCD_DP_ITER_COUNT_EN is defined)
//
// Configuration macro: GCD_DP_ITER_COUNT_EN adds the iter_count port and its
// CW-bit counter. Without it, neither the port nor the counter exists.
// -----------------------------------------------------------------------------
module gcd_datapath #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    controlarr,
  input  logic [W-1:0]  xin,
  input  logic [W-1:0]  yin,
  output logic          endflag,
  output logic          swapflag,
  output logic [W-1:0]  result,
  output logic          done,
  output logic          err
`ifdef GCD_DP_ITER_COUNT_EN
  ,
  output logic [CW-1:0] iter_count
`endif
);

  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic cmd_sub, cmd_swap, cmd_load, x_en, y_en;
  logic sub_exec;

  assign cmd_sub  = controlarr[0];
  assign cmd_swap = controlarr[1];
  assign cmd_load = controlarr[2];
  assign x_en     = controlarr[3];
  assign y_en     = controlarr[4];

  // Flags depend only on the registers, never on the incoming command.
  assign endflag  = (y_q == '0);
  assign swapflag = (x_q < y_q);
  assign result   = x_q;
  assign done     = done_q;
  assign err      = err_q;

  // A subtract really happens only when it is not overridden by load or
  // swap and X is write-enabled.
  assign sub_exec = !cmd_load && !cmd_swap && cmd_sub && x_en;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    x_d    = x_q;
    y_d    = y_q;
    done_d = done_q;
    err_d  = err_q;

    if (cmd_load) begin
      if (x_en) x_d = xin;
      if (y_en) y_d = yin;
      done_d = 1'b0;
    end else begin
      if (cmd_swap) begin
        // Both sides read the old register values, so enabling both
        // enables gives a true exchange.
        if (x_en) x_d = y_q;
        if (y_en) y_d = x_q;
        // Swap wins over a simultaneous subtract. The combination is still
        // flagged, but only when the command actually writes something.
        if (cmd_sub && (x_en || y_en)) err_d = 1'b1;
      end else if (sub_exec) begin
        x_d = x_q - y_q;  // wraps modulo 2^W when X < Y
        if (swapflag) err_d = 1'b1;
      end
      if (endflag) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, which keeps the swap race-free.
    if (reset) begin
      x_q    <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

`ifdef GCD_DP_ITER_COUNT_EN
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (cmd_load) begin
      cnt_d = '0;
    end else if (sub_exec && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;  // saturates at all-ones
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign iter_count = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_datapath.sv
module tb_gcd_datapath;

  localparam int W    = 8;
  localparam int CW   = 4;  // small so saturation is reachable quickly
  localparam int MODW = 1 << W;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    controlarr;
  logic [W-1:0]  xin, yin;
  logic          endflag, swapflag, done, err;
  logic [W-1:0]  result;
`ifdef GCD_DP_ITER_COUNT_EN
  logic [CW-1:0] iter_count;
`endif

  gcd_datapath #(.W(W), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .controlarr (controlarr),
    .xin        (xin),
    .yin        (yin),
    .endflag    (endflag),
    .swapflag   (swapflag),
    .result     (result),
    .done       (done),
    .err        (err)
`ifdef GCD_DP_ITER_COUNT_EN
    ,
    .iter_count (iter_count)
`endif
  );

  always #5 clk = ~clk;

  // Command encodings: {yen, xen, load, swap, sub}
  localparam logic [4:0] C_LOAD  = 5'b11100;
  localparam logic [4:0] C_SWAP  = 5'b11010;
  localparam logic [4:0] C_SUBX  = 5'b01001;
  localparam logic [4:0] C_HOLD  = 5'b00000;
  localparam logic [4:0] C_BAD   = 5'b11011;

  typedef struct {
    int res;
    bit ef;
    bit sf;
    bit dn;
    bit er;
    int cnt;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // Reference state: the GCD machine described as plain integers.
  int mx, my, mcnt;
  bit mdone, merr;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Apply one command's meaning to the reference state.
  task automatic model_step(input bit rst, input logic [4:0] c, input int xi, input int yi);
    bit sub, swp, ld, xe, ye, was_end;
    int ox, oy;
    sub = c[0]; swp = c[1]; ld = c[2]; xe = c[3]; ye = c[4];
    ox = mx; oy = my;
    was_end = (oy == 0);
    if (rst) begin
      mx = 0; my = 0; mdone = 0; merr = 0; mcnt = 0;
    end else if (ld) begin
      if (xe) mx = xi;
      if (ye) my = yi;
      mdone = 0;
      mcnt  = 0;
    end else begin
      if (swp) begin
        if (xe) mx = oy;
        if (ye) my = ox;
        if (sub && (xe || ye)) merr = 1;
      end else if (sub && xe) begin
        if (ox < oy) merr = 1;
        mx   = (ox - oy + MODW) % MODW;
        mcnt = (mcnt < CMAX) ? mcnt + 1 : CMAX;
      end
      if (was_end) mdone = 1;
    end
  endtask

  // Drive one command for one cycle and record what must follow it.
  task automatic issue(input bit rst, input logic [4:0] c, input int xi, input int yi);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    controlarr = c;
    xin        = W'(xi);
    yin        = W'(yi);
    model_step(rst, c, xi, yi);
    e.res = mx; e.ef = (my == 0); e.sf = (mx < my);
    e.dn = mdone; e.er = merr; e.cnt = mcnt;
    sb.push_back(e);
  endtask

  // Full algorithm driven from the reference's own flags, then one idle
  // cycle so done can rise.
  task automatic run_gcd(input int a, input int b);
    issue(0, C_LOAD, a, b);
    for (int i = 0; i < 600; i++) begin
      if (my == 0) break;
      issue(0, (mx < my) ? C_SWAP : C_SUBX, 0, 0);
    end
    issue(0, C_HOLD, 0, 0);
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("result",   int'(result),   e.res);
        check("endflag",  int'(endflag),  int'(e.ef));
        check("swapflag", int'(swapflag), int'(e.sf));
        check("done",     int'(done),     int'(e.dn));
        check("err",      int'(err),      int'(e.er));
`ifdef GCD_DP_ITER_COUNT_EN
        check("iter_count", int'(iter_count), e.cnt);
`endif
      end
    end
  end

  initial begin
    reset = 1'b1; controlarr = C_LOAD; xin = '0; yin = '0;
    mx = 0; my = 0; mcnt = 0; mdone = 0; merr = 0;

    // Reset for two cycles with a load pending: reset must win.
    issue(1, C_LOAD, 77, 99);
    issue(1, C_LOAD, 77, 99);

    // Worked example 48/18 -> 6 with five subtracts.
    run_gcd(48, 18);

    // Swap on X<Y, then an X-only subtract.
    issue(0, C_LOAD, 5, 12);
    issue(0, C_SWAP, 0, 0);
    issue(0, C_SUBX, 0, 0);

    // Zero operands.
    run_gcd(0, 37);
    run_gcd(0, 0);
    run_gcd(91, 0);

    // Enables off: non-load commands change nothing.
    issue(0, C_LOAD, 9, 4);
    issue(0, 5'b00011, 0, 0);
    issue(0, 5'b00001, 0, 0);
    issue(0, 5'b00010, 0, 0);

    // Reset in the middle of a subtract.
    issue(0, C_LOAD, 200, 3);
    issue(0, C_SUBX, 0, 0);
    issue(1, C_SUBX, 0, 0);
    issue(0, C_HOLD, 0, 0);

    // Subtract counter saturation, then cleared by load.
    issue(0, C_LOAD, 255, 1);
    for (int i = 0; i < CMAX + 3; i++) issue(0, C_SUBX, 0, 0);
    issue(0, C_LOAD, 10, 10);

    // Illegal swap+subtract on X=9, Y=4; err survives a later load.
    issue(0, C_LOAD, 9, 4);
    issue(0, C_BAD, 0, 0);
    issue(0, C_LOAD, 30, 12);
    run_gcd(30, 12);
    issue(1, C_HOLD, 0, 0);

    // Illegal subtract with X<Y writes the wrapped value.
    issue(0, C_LOAD, 3, 10);
    issue(0, C_SUBX, 0, 0);
    issue(1, C_HOLD, 0, 0);

    // Random complete GCD runs.
    for (int n = 0; n < 20; n++) run_gcd($urandom_range(0, 255), $urandom_range(0, 255));

    // Random raw command stream with occasional reset.
    for (int n = 0; n < 300; n++)
      issue($urandom_range(0, 19) == 0, 5'($urandom), $urandom_range(0, 255), $urandom_range(0, 255));

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
